// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, game states and the
// default palette shared by the frame scanner and its axis counters.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10,
    RSVD = 2'b11
  } game_state_t;

  localparam logic [11:0] PAL_BG    = 12'hFFF;
  localparam logic [11:0] PAL_GREY  = 12'h535;
  localparam logic [11:0] PAL_WHITE = 12'hFFF;

  // Only the running and game-over screens draw anything.
  function automatic logic shows_colour(game_state_t gs);
    return (gs == RUN) || (gs == OVER);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (active, front porch, sync, back porch).
// Ports: clk_i, rst_i (sync, high), en_i step enable; cnt_o position,
// wrap_o (en_i on last count), sync_n_o (active-low sync), active_o.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int TOTAL  = ACTIVE + FP + SYNC + BP,
  parameter int W      = $clog2(TOTAL + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         sync_n_o,
  output logic         active_o
);

  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT   = W'(ACTIVE);
  localparam logic [W-1:0] S_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] S_END = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign wrap_o   = en_i && (cnt_q == LAST);
  assign sync_n_o = !((cnt_q >= S_BEG) && (cnt_q < S_END));
  assign active_o = cnt_q < ACT;

endmodule

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: raster scan, delegate query, registered RGB/sync.
// Ports: PixelClk, rst (sync, high), gameState, inGrey/inWhite (same-cycle
// delegate answers); vgaX/vgaY query position; frameTick, inDisplay,
// hsync/vsync (active-low), rgb -- all registered, aligned to one pixel.
// Build option NIGHT_MODE_EN adds nightMode input, latched per frame.
module vga_frame_scanner
  import vga_timing_pkg::*;
#(
  parameter int          H_ACTIVE    = VGA_H_ACTIVE,
  parameter int          H_FP        = VGA_H_FP,
  parameter int          H_SYNC      = VGA_H_SYNC,
  parameter int          H_BP        = VGA_H_BP,
  parameter int          V_ACTIVE    = VGA_V_ACTIVE,
  parameter int          V_FP        = VGA_V_FP,
  parameter int          V_SYNC      = VGA_V_SYNC,
  parameter int          V_BP        = VGA_V_BP,
  parameter logic [11:0] COLOR_BG    = PAL_BG,
  parameter logic [11:0] COLOR_GREY  = PAL_GREY,
  parameter logic [11:0] COLOR_WHITE = PAL_WHITE
) (
  input  logic        PixelClk,
  input  logic        rst,
  input  logic [1:0]  gameState,
  input  logic        inGrey,
  input  logic        inWhite,
`ifdef NIGHT_MODE_EN
  input  logic        nightMode,
`endif
  output logic [31:0] vgaX,
  output logic [31:0] vgaY,
  output logic        frameTick,
  output logic        inDisplay,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);

  logic [HW-1:0] h_cnt;
  logic          h_wrap;
  logic          h_sync_n;
  logic          h_act;
  logic [VW-1:0] v_cnt;
  logic          v_wrap_unused;
  logic          v_sync_n;
  logic          v_act;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
  ) u_h (
    .clk_i   (PixelClk),
    .rst_i   (rst),
    .en_i    (1'b1),
    .cnt_o   (h_cnt),
    .wrap_o  (h_wrap),
    .sync_n_o(h_sync_n),
    .active_o(h_act)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
  ) u_v (
    .clk_i   (PixelClk),
    .rst_i   (rst),
    .en_i    (h_wrap),
    .cnt_o   (v_cnt),
    .wrap_o  (v_wrap_unused),
    .sync_n_o(v_sync_n),
    .active_o(v_act)
  );

  assign vgaX = 32'(h_cnt);
  assign vgaY = 32'(v_cnt);

  game_state_t gs;
  logic        vis;
  logic        night;
  logic        tick_d;
  logic [11:0] rgb_d;

  logic        tick_q;
  logic        disp_q;
  logic        hs_q;
  logic        vs_q;
  logic [11:0] rgb_q;

  assign gs  = game_state_t'(gameState);
  assign vis = h_act && v_act;

  // Last pixel of the last visible line: the registered pulse then
  // lands on the first vblank cycle.
  assign tick_d = h_wrap && (v_cnt == V_LAST_ACT);

`ifdef NIGHT_MODE_EN
  logic night_q;

  // Sampled only on the tick so a frame never switches mode midway.
  always_ff @(posedge PixelClk) begin
    if (rst) begin
      night_q <= 1'b0;
    end else if (tick_q) begin
      night_q <= nightMode;
    end
  end

  assign night = night_q;
`else
  assign night = 1'b0;
`endif

  always_comb begin
    rgb_d = '0;
    if (vis && shows_colour(gs)) begin
      if (inGrey) begin
        rgb_d = COLOR_GREY;
      end else if (inWhite) begin
        rgb_d = COLOR_WHITE;
      end else begin
        rgb_d = COLOR_BG;
      end
    end
    if (night && (rgb_d != '0)) begin
      rgb_d = ~rgb_d;
    end
  end

  always_ff @(posedge PixelClk) begin
    if (rst) begin
      tick_q <= 1'b0;
      disp_q <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      rgb_q  <= '0;
    end else begin
      tick_q <= tick_d;
      disp_q <= vis;
      hs_q   <= h_sync_n;
      vs_q   <= v_sync_n;
      rgb_q  <= rgb_d;
    end
  end

  assign frameTick = tick_q;
  assign inDisplay = disp_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: self-checking bench on a shrunken raster,
// vector table + hand sequences + randomized run against a raster model.
module tb_vga_frame_scanner;

  localparam int HA = 64, HFP = 4, HS = 8, HB = 4;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VA = 16, VFP = 2, VS = 2, VB = 3;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  gameState = 2'b01;
  logic        inGrey;
  logic        inWhite;
  logic        nightMode = 1'b0;
  logic [31:0] vgaX;
  logic [31:0] vgaY;
  logic        frameTick;
  logic        inDisplay;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;

  logic use_map = 1'b0;
  logic cg = 1'b0;
  logic cw = 1'b0;
  logic grey_map  [HT][VT];
  logic white_map [HT][VT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_frame_scanner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .PixelClk (clk),
    .rst      (rst),
    .gameState(gameState),
    .inGrey   (inGrey),
    .inWhite  (inWhite),
`ifdef NIGHT_MODE_EN
    .nightMode(nightMode),
`endif
    .vgaX     (vgaX),
    .vgaY     (vgaY),
    .frameTick(frameTick),
    .inDisplay(inDisplay),
    .hsync    (hsync),
    .vsync    (vsync),
    .rgb      (rgb)
  );

  // Delegate stand-in: combinational answer on the queried position.
  always_comb begin
    inGrey  = cg;
    inWhite = cw;
    if (use_map && vgaX < 32'(HT) && vgaY < 32'(VT)) begin
      inGrey  = grey_map[int'(vgaX)][int'(vgaY)];
      inWhite = white_map[int'(vgaX)][int'(vgaY)];
    end
  end

  typedef struct {
    logic [1:0]  gs;
    logic        g;
    logic        w;
    int          x;
    int          y;
    logic [11:0] rgb;
    logic        disp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_pos(int x, int y);
    int n;
    n = 0;
    while (!(vgaX == 32'(x) && vgaY == 32'(y)) && n < FRAME + HT) begin
      step();
      n++;
    end
    n_cmp++;
    if (vgaX != 32'(x) || vgaY != 32'(y)) begin
      n_bad++;
      $display("FAIL wait_pos(%0d,%0d): at (%0d,%0d) expected reach",
               x, y, vgaX, vgaY);
    end
  endtask

  task automatic wait_tick(int budget, output int n);
    n = 0;
    while (frameTick !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Pixel colour straight from the palette rules.
  function automatic logic [11:0] model_rgb(int x, int y, logic [1:0] g,
                                            logic gr, logic wh, logic nm);
    logic [11:0] c;
    if (!(x < HA && y < VA) || g == 2'b00 || g == 2'b11) return 12'h000;
    c = gr ? 12'h535 : (wh ? 12'hFFF : 12'hFFF);
    if (nm && c != 12'h000) c = ~c;
    return c;
  endfunction

  task automatic run_random(int n);
    int x, y, nx, ny;
    logic nm_model;
    logic ehs, evs, edisp, etick;
    logic [47:0] act, exp;
    nm_model = 1'b0;
    for (int k = 0; k < n; k++) begin
      x  = k % HT;
      y  = (k / HT) % VT;
      nx = (k + 1) % HT;
      ny = ((k + 1) / HT) % VT;
      gameState = 2'($urandom_range(0, 3));
`ifdef NIGHT_MODE_EN
      nightMode = 1'($urandom_range(0, 1));
`endif
      ehs   = !(x >= HA + HFP && x < HA + HFP + HS);
      evs   = !(y >= VA + VFP && y < VA + VFP + VS);
      edisp = (x < HA) && (y < VA);
      etick = (x == HT - 1) && (y == VA - 1);
      exp = {16'(nx), 16'(ny), ehs, evs, edisp, etick,
             model_rgb(x, y, gameState, grey_map[x][y],
                       white_map[x][y], nm_model)};
      step();
      act = {vgaX[15:0], vgaY[15:0], hsync, vsync, inDisplay,
             frameTick, rgb};
      chk($sformatf("rand k=%0d", k), 64'(act), 64'(exp));
      if (x == 0 && y == VA) nm_model = nightMode;
      if (n_bad > 20) break;
    end
  endtask

  initial begin
    int cnt;

    for (int i = 0; i < HT; i++) begin
      for (int j = 0; j < VT; j++) begin
        grey_map[i][j]  = 1'($urandom_range(0, 1));
        white_map[i][j] = 1'($urandom_range(0, 1));
      end
    end

    vecs[0]  = '{2'b01, 1'b1, 1'b1, 30, 12, 12'h535, 1'b1};
    vecs[1]  = '{2'b01, 1'b0, 1'b1, 30, 12, 12'hFFF, 1'b1};
    vecs[2]  = '{2'b01, 1'b0, 1'b0, 30, 12, 12'hFFF, 1'b1};
    vecs[3]  = '{2'b01, 1'b1, 1'b0, 30, 12, 12'h535, 1'b1};
    vecs[4]  = '{2'b01, 1'b1, 1'b0, 70, 5,  12'h000, 1'b0};
    vecs[5]  = '{2'b00, 1'b1, 1'b0, 30, 12, 12'h000, 1'b1};
    vecs[6]  = '{2'b11, 1'b1, 1'b0, 30, 12, 12'h000, 1'b1};
    vecs[7]  = '{2'b10, 1'b1, 1'b0, 30, 12, 12'h535, 1'b1};
    vecs[8]  = '{2'b01, 1'b1, 1'b1, 10, 20, 12'h000, 1'b0};
    vecs[9]  = '{2'b01, 1'b0, 1'b1, 63, 15, 12'hFFF, 1'b1};
    vecs[10] = '{2'b01, 1'b1, 1'b0, 64, 15, 12'h000, 1'b0};
    vecs[11] = '{2'b01, 1'b1, 1'b0, 0,  16, 12'h000, 1'b0};
    vecs[12] = '{2'b10, 1'b1, 1'b0, 0,  0,  12'h535, 1'b1};

    do_reset();
    chk("reset vgaX", 64'(vgaX), 64'd0);
    chk("reset vgaY", 64'(vgaY), 64'd0);
    chk("reset syncs", 64'({hsync, vsync}), 64'd3);
    chk("reset rgb", 64'(rgb), 64'd0);
    chk("reset tick/disp", 64'({frameTick, inDisplay}), 64'd0);

    use_map = 1'b1;
    run_random(2 * FRAME + 50);

    nightMode = 1'b0;
    gameState = 2'b01;
    do_reset();
    repeat (HT) step();
    chk("line wrap x", 64'(vgaX), 64'd0);
    chk("line wrap y", 64'(vgaY), 64'd1);

    wait_pos(0, 3);
    cnt = 0;
    while (hsync === 1'b1 && cnt < 2 * HT) begin step(); cnt++; end
    chk("hsync start", 64'(cnt), 64'(HA + HFP + 1));
    cnt = 0;
    while (hsync === 1'b0 && cnt < 2 * HT) begin step(); cnt++; end
    chk("hsync width", 64'(cnt), 64'(HS));
    cnt = 0;
    while (vsync === 1'b1 && cnt < FRAME + HT) begin step(); cnt++; end
    chk("vsync line", 64'(vgaY), 64'(VA + VFP));
    chk("vsync col", 64'(vgaX), 64'd1);
    cnt = 0;
    while (vsync === 1'b0 && cnt < FRAME) begin step(); cnt++; end
    chk("vsync width", 64'(cnt), 64'(VS * HT));
    wait_tick(FRAME + HT, cnt);
    chk("tick pos", {vgaX, vgaY}, {32'd0, 32'(VA)});
    step();
    chk("tick width", 64'(frameTick), 64'd0);
    wait_tick(2 * FRAME, cnt);
    chk("tick period", 64'(cnt + 1), 64'(FRAME));

    use_map = 1'b0;
    for (int i = 0; i < NV; i++) begin
      gameState = vecs[i].gs;
      cg = vecs[i].g;
      cw = vecs[i].w;
      wait_pos(vecs[i].x, vecs[i].y);
      step();
      chk($sformatf("vec%0d rgb", i), 64'(rgb), 64'(vecs[i].rgb));
      chk($sformatf("vec%0d disp", i), 64'(inDisplay), 64'(vecs[i].disp));
    end

    gameState = 2'b01;
    cg = 1'b1;
    cw = 1'b0;
    wait_pos(30, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst vgaX", 64'(vgaX), 64'd0);
    chk("midrst vgaY", 64'(vgaY), 64'd0);
    chk("midrst tick", 64'(frameTick), 64'd0);
    wait_tick(2 * FRAME, cnt);
    chk("midrst first tick", 64'(cnt), 64'(VA * HT));

`ifdef NIGHT_MODE_EN
    wait_pos(0, 3);
    nightMode = 1'b1;
    wait_pos(30, 12);
    step();
    chk("night same frame", 64'(rgb), 64'h535);
    wait_tick(2 * FRAME, cnt);
    step();
    wait_pos(70, 5);
    step();
    chk("night blank", 64'(rgb), 64'h000);
    wait_pos(30, 12);
    step();
    chk("night next frame", 64'(rgb), 64'hACA);
    nightMode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
